// File: rtl/scytale_decryption_pkg.sv
// Shared definitions for the scytale decryptor: default widths, the in-band
// start token and the controller state encoding.
package scytale_decryption_pkg;

  localparam int         D_WIDTH_DEF     = 8;
  localparam int         KEY_WIDTH_DEF   = 8;
  localparam logic [7:0] START_TOKEN_DEF = 8'hFA;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECRYPT = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/scytale_decryption_char_buffer.sv
// Ciphertext character store: one synchronous write port and one registered
// read port. Contents are deliberately not reset.
module scytale_char_buffer #(
  parameter int DEPTH   = 50,
  parameter int D_WIDTH = 8,
  parameter int ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [D_WIDTH-1:0] rd_data
);

  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic [D_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/scytale_decryption.sv
// Scytale decryptor: collects ciphertext until the start token, then re-reads
// the buffer column-major and streams plaintext one character per cycle.
module scytale_decryption
  import scytale_decryption_pkg::*;
#(
  parameter int                 D_WIDTH                = D_WIDTH_DEF,
  parameter int                 KEY_WIDTH              = KEY_WIDTH_DEF,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = D_WIDTH'(START_TOKEN_DEF)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 busy
);

  localparam int CNT_W  = $clog2(MAX_NOF_CHARS + 1);
  localparam int ADDR_W = $clog2(MAX_NOF_CHARS);
  localparam int LEN_W  = 2 * KEY_WIDTH;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     wr_cnt_q, wr_cnt_d;
  logic [KEY_WIDTH-1:0] kn_q, kn_d, km_q, km_d;
  logic [KEY_WIDTH-1:0] r_q, r_d, c_q, c_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     idx_q, idx_d;
  logic [LEN_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic                 rd_vld_q, rd_vld_d;
  logic [D_WIDTH-1:0]   data_o_q, data_o_d;
  logic                 valid_o_q, valid_o_d;
  logic                 busy_q, busy_d;

  logic                 wr_en, rd_en;
  logic [ADDR_W-1:0]    rd_addr;
  logic [D_WIDTH-1:0]   rd_data;
  logic [LEN_W-1:0]     prod;
  logic                 last_row;

  scytale_char_buffer #(
    .DEPTH   (MAX_NOF_CHARS),
    .D_WIDTH (D_WIDTH),
    .ADDR_W  (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (ADDR_W'(wr_cnt_q)),
    .wr_data (data_i),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    kn_d     = kn_q;
    km_d     = km_q;
    r_d      = r_q;
    c_d      = c_q;
    len_d    = len_q;
    idx_d    = idx_q;
    rd_cnt_d = rd_cnt_q;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    prod     = LEN_W'(key_N) * LEN_W'(key_M);
    last_row = ({1'b0, r_q} + 1'b1) >= {1'b0, km_q};
    // Long keys can walk idx past the buffer end; pin it to the last slot.
    rd_addr  = (idx_q > LEN_W'(MAX_NOF_CHARS - 1)) ? ADDR_W'(MAX_NOF_CHARS - 1)
                                                    : ADDR_W'(idx_q);

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (data_i == START_DECRYPTION_TOKEN) begin
            kn_d     = key_N;
            km_d     = key_M;
            len_d    = (prod > LEN_W'(MAX_NOF_CHARS)) ? LEN_W'(MAX_NOF_CHARS) : prod;
            idx_d    = '0;
            r_d      = '0;
            c_d      = '0;
            rd_cnt_d = '0;
            state_d  = DECRYPT;
          end else if (wr_cnt_q < CNT_W'(MAX_NOF_CHARS)) begin
            wr_en    = 1'b1;
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      DECRYPT: begin
        if (rd_cnt_q < len_q) begin
          rd_en    = 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (!last_row) begin
            idx_d = idx_q + LEN_W'(kn_q);
            r_d   = r_q + 1'b1;
          end else begin
            r_d   = '0;
            c_d   = c_q + 1'b1;
            idx_d = LEN_W'(c_q) + 1'b1;
          end
        end else begin
          // Last read already issued; its data leaves on this edge.
          state_d = DONE;
        end
      end
      DONE: begin
        wr_cnt_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rd_vld_d  = rd_en;
    busy_d    = (state_q == DECRYPT);
    valid_o_d = (state_q == DECRYPT) && rd_vld_q;
    data_o_d  = valid_o_d ? rd_data : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_cnt_q  <= '0;
      kn_q      <= '0;
      km_q      <= '0;
      r_q       <= '0;
      c_q       <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      rd_cnt_q  <= '0;
      rd_vld_q  <= 1'b0;
      data_o_q  <= '0;
      valid_o_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      kn_q      <= kn_d;
      km_q      <= km_d;
      r_q       <= r_d;
      c_q       <= c_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_vld_q  <= rd_vld_d;
      data_o_q  <= data_o_d;
      valid_o_q <= valid_o_d;
      busy_q    <= busy_d;
    end
  end

  assign data_o  = data_o_q;
  assign valid_o = valid_o_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_scytale_decryption.sv
// Self-checking bench for scytale_decryption: a reference buffer model fills a
// queue of expected plaintext at each token; outputs are sampled on negedges.
module tb_scytale_decryption;

  localparam int         MAX   = 50;
  localparam logic [7:0] TOKEN = 8'hFA;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_i, key_N, key_M;
  logic       valid_i;
  logic [7:0] data_o;
  logic       valid_o, busy;

  logic [7:0] model_buf [MAX];
  int         model_wr;
  logic [7:0] exp_q [$];
  int         vectors;
  int         miscompares;

  always #5 clk = ~clk;

  scytale_decryption dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .valid_i (valid_i),
    .key_N   (key_N),
    .key_M   (key_M),
    .data_o  (data_o),
    .valid_o (valid_o),
    .busy    (busy)
  );

  task automatic send(input logic [7:0] ch);
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = ch;
    if (ch != TOKEN && model_wr < MAX) begin
      model_buf[model_wr] = ch;
      model_wr++;
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic send_str(input string s, input bit gapped);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      if (gapped) idle_cycle();
    end
    send(TOKEN);
  endtask

  task automatic drive_gap(input bit noise);
    if (noise) begin
      valid_i = 1'b1;
      data_i  = 8'($urandom);
    end else begin
      valid_i = 1'b0;
    end
  endtask

  // Called right after the token was driven; observes edges T .. T+L+2.
  task automatic run_output(input int kn, input int km, input bit noise, input bit chg_keys);
    int l;
    logic [7:0] exp_ch;
    l = kn * km;
    if (l > MAX) l = MAX;
    for (int k = 0; k < l; k++) begin
      int a;
      a = (k % km) * kn + k / km;
      if (a > MAX - 1) a = MAX - 1;
      exp_q.push_back(model_buf[a]);
    end
    model_wr = 0;

    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL tok_edge: busy=%b valid_o=%b expected busy=0 valid_o=0", busy, valid_o);
    end
    drive_gap(noise);
    if (chg_keys) begin
      key_N = 8'd3;
      key_M = 8'd7;
    end

    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_rise: busy=%b valid_o=%b expected busy=1 valid_o=0", busy, valid_o);
    end
    drive_gap(noise);

    for (int k = 0; k < l; k++) begin
      @(negedge clk);
      exp_ch = exp_q.pop_front();
      vectors++;
      if (valid_o !== 1'b1 || busy !== 1'b1 || data_o !== exp_ch) begin
        miscompares++;
        $display("FAIL char%0d: valid_o=%b busy=%b data_o=%h expected valid_o=1 busy=1 data_o=%h",
                 k, valid_o, busy, data_o, exp_ch);
      end
      drive_gap(noise);
    end

    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || valid_o !== 1'b0 || data_o !== 8'h00) begin
      miscompares++;
      $display("FAIL end: busy=%b valid_o=%b data_o=%h expected 0 0 00", busy, valid_o, data_o);
    end
    valid_i = 1'b0;
    $display("decrypt kN=%0d kM=%0d: %0d chars checked", kn, km, l);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (data_o !== 8'h00 || valid_o !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: data_o=%h valid_o=%b busy=%b expected 00 0 0", data_o, valid_o, busy);
    end
    rst_n    = 1'b1;
    model_wr = 0;
    $display("reset checked");
  endtask

  task automatic test_basic();
    key_N = 8'd2;
    key_M = 8'd3;
    send_str("ADBECF", 1'b0);
    run_output(2, 3, 1'b0, 1'b0);
  endtask

  task automatic test_gapped();
    key_N = 8'd2;
    key_M = 8'd3;
    send_str("ADBECF", 1'b1);
    run_output(2, 3, 1'b0, 1'b0);
  endtask

  task automatic test_zero_key();
    key_N = 8'd0;
    key_M = 8'd5;
    send_str("XY", 1'b0);
    run_output(0, 5, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    key_N = 8'd2;
    key_M = 8'd3;
    send_str("ADBECF", 1'b0);
    idle_cycle();
    idle_cycle();
    @(negedge clk);
    vectors++;
    if (valid_o !== 1'b1 || data_o !== 8'h41) begin
      miscompares++;
      $display("FAIL mid_char0: valid_o=%b data_o=%h expected 1 41", valid_o, data_o);
    end
    @(negedge clk);
    vectors++;
    if (valid_o !== 1'b1 || data_o !== 8'h42) begin
      miscompares++;
      $display("FAIL mid_char1: valid_o=%b data_o=%h expected 1 42", valid_o, data_o);
    end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (valid_o !== 1'b0 || busy !== 1'b0 || data_o !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset: valid_o=%b busy=%b data_o=%h expected 0 0 00", valid_o, busy, data_o);
    end
    rst_n    = 1'b1;
    model_wr = 0;
    $display("reset mid-output checked");
    test_basic();
  endtask

  task automatic test_overflow();
    key_N = 8'd5;
    key_M = 8'd10;
    for (int i = 0; i < 52; i++) send(8'(8'h20 + i));
    send(TOKEN);
    run_output(5, 10, 1'b0, 1'b1);
  endtask

  task automatic test_input_during_busy();
    key_N = 8'd3;
    key_M = 8'd2;
    send_str("ADBECF", 1'b0);
    run_output(3, 2, 1'b1, 1'b0);
    key_N = 8'd2;
    key_M = 8'd2;
    send_str("HLEO", 1'b0);
    run_output(2, 2, 1'b0, 1'b0);
  endtask

  task automatic test_clamp();
    key_N = 8'd3;
    key_M = 8'd20;
    send_str("WXYZ", 1'b0);
    run_output(3, 20, 1'b0, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_wr    = 0;
    rst_n       = 1'b0;
    valid_i     = 1'b0;
    data_i      = 8'h00;
    key_N       = 8'h00;
    key_M       = 8'h00;
    test_reset();
    test_basic();
    test_gapped();
    test_zero_key();
    test_reset_mid();
    test_overflow();
    test_input_during_busy();
    test_clamp();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
